// File: rtl/mux_demux_pkg.sv
// rtl/mux_demux_pkg.sv - shared helpers for the N-lane mux/pipe/demux block
// Purpose: lane-select width calculation and one-hot encoding used by the
//          top level and the round-robin arbiter.
// Ports:   none (package).
package mux_demux_pkg;

    // Upper bound on lane count supported by the one-hot helper.
    localparam int MAX_LANES = 64;

    // Width of a lane index; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One-hot vector with bit idx set; all zero when idx is out of range.
    function automatic logic [MAX_LANES-1:0] onehot(input int idx, input int n);
        logic [MAX_LANES-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n) begin
            v = MAX_LANES'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - N-way round-robin arbiter with advance enable
// Purpose: picks the first valid lane at or after the rotating pointer.
//          The pointer moves past the granted lane only when advance is high.
// Ports:   clock, reset (sync, active-high), valid[N] requests, advance
//          (grant is being taken this cycle), grant[N] one-hot, idx encoded.
module rr_arbiter_n
    import mux_demux_pkg::*;
#(
    parameter int ID = 1,
    parameter int N  = 4,
    localparam int SELW = sel_width(N)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    valid,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0]      r_ptr;
    logic                 w_found;
    logic [SELW-1:0]      w_idx;
    logic [SELW-1:0]      w_lane;
    logic [MAX_LANES-1:0] w_onehot;

    // Scan lanes starting at the pointer, wrapping N-1 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_lane  = '0;
        for (int i = 0; i < N; i++) begin
            w_lane = SELW'((int'(r_ptr) + i) % N);
            if (!w_found && valid[w_lane]) begin
                w_found = 1'b1;
                w_idx   = w_lane;
            end
        end
    end

    assign w_onehot = onehot(int'(w_idx), N);
    assign grant    = w_found ? w_onehot[N-1:0] : '0;
    assign idx      = w_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= (w_idx == SELW'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_to_demux_n_pipe.sv
// rtl/mux_to_demux_n_pipe.sv - N-lane mux into a registered pipe, demuxed to the same lane
// Purpose: time-multiplexes N input lanes onto one PIPE-deep registered path
//          and writes each word back out on the output lane it came from.
// Ports:   clock, reset (sync, active-high), inp[N][WIDTH], in_valid[N],
//          sel (explicit lane, ignored when RR=1), stall (freezes everything),
//          in_grant[N] combinational one-hot capture, outp[N][WIDTH] per-lane
//          held data, out_valid[N] one-cycle one-hot delivery pulse.
module mux_to_demux_n_pipe
    import mux_demux_pkg::*;
#(
    parameter int ID    = 1,
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int PIPE  = 2,
    parameter int RR    = 0,
    localparam int SELW = sel_width(N)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N-1:0][WIDTH-1:0]   inp,
    input  logic [N-1:0]              in_valid,
    input  logic [SELW-1:0]           sel,
    input  logic                      stall,
    output logic [N-1:0]              in_grant,
    output logic [N-1:0][WIDTH-1:0]   outp,
    output logic [N-1:0]              out_valid
);

    typedef struct packed {
        logic             valid;
        logic [SELW-1:0]  lane;
        logic [WIDTH-1:0] data;
    } stage_t;

    logic            w_can_capture;
    logic [N-1:0]    w_grant;
    logic [SELW-1:0] w_grant_idx;
    stage_t          w_stage_in;

    // Reset and stall both suppress capture so upstream keeps its word.
    assign w_can_capture = !stall && !reset;

    generate
        if (RR != 0) begin : g_rr
            logic [N-1:0]    w_arb_grant;
            logic [SELW-1:0] w_arb_idx;

            rr_arbiter_n #(
                .ID (ID),
                .N  (N)
            ) u_arb (
                .clock   (clock),
                .reset   (reset),
                .valid   (in_valid),
                .advance (w_can_capture),
                .grant   (w_arb_grant),
                .idx     (w_arb_idx)
            );

            assign w_grant     = w_can_capture ? w_arb_grant : '0;
            assign w_grant_idx = w_arb_idx;
        end else begin : g_sel
            logic                 w_sel_ok;
            logic [MAX_LANES-1:0] w_sel_onehot;

            // Out-of-range select never grants, even when N is not a power of two.
            assign w_sel_ok     = (int'(sel) < N);
            assign w_sel_onehot = onehot(int'(sel), N);
            assign w_grant      = (w_can_capture && w_sel_ok && in_valid[sel])
                                  ? w_sel_onehot[N-1:0] : '0;
            assign w_grant_idx  = sel;
        end
    endgenerate

    assign in_grant = w_grant;

    always_comb begin
        w_stage_in       = '0;
        w_stage_in.valid = |w_grant;
        w_stage_in.lane  = w_grant_idx;
        w_stage_in.data  = inp[w_grant_idx];
    end

    // w_chain[k] feeds stage k; w_chain[PIPE] is the last stage's contents.
    stage_t w_chain [PIPE+1];
    assign w_chain[0] = w_stage_in;

    generate
        for (genvar k = 0; k < PIPE; k++) begin : g_stage
            stage_t r_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_q <= '0;
                end else if (!stall) begin
                    r_q <= w_chain[k];
                end
            end

            assign w_chain[k+1] = r_q;
        end
    endgenerate

    stage_t                  w_last;
    logic [MAX_LANES-1:0]    w_last_onehot;
    logic [N-1:0][WIDTH-1:0] r_outp;
    logic [N-1:0]            r_out_valid;

    assign w_last        = w_chain[PIPE];
    assign w_last_onehot = onehot(int'(w_last.lane), N);

    // Only the addressed lane is rewritten; the others keep their last word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_outp      <= '0;
            r_out_valid <= '0;
        end else if (!stall) begin
            if (w_last.valid) begin
                r_outp[w_last.lane] <= w_last.data;
                r_out_valid         <= w_last_onehot[N-1:0];
            end else begin
                r_out_valid <= '0;
            end
        end
    end

    assign outp      = r_outp;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_to_demux_n_pipe.sv
// tb/tb_mux_to_demux_n_pipe.sv - directed self-checking bench for mux_to_demux_n_pipe
module tb_mux_to_demux_n_pipe;

    logic             clock;
    logic             reset;
    logic [3:0][15:0] inp;
    logic [3:0]       in_valid;
    logic [1:0]       sel;
    logic             stall;

    logic [3:0]       grant_e, grant_r;
    logic [3:0][15:0] outp_e, outp_r;
    logic [3:0]       out_valid_e, out_valid_r;

    int total;
    int bad;

    mux_to_demux_n_pipe #(.ID(1), .N(4), .WIDTH(16), .PIPE(2), .RR(0)) dut_e (
        .clock     (clock),
        .reset     (reset),
        .inp       (inp),
        .in_valid  (in_valid),
        .sel       (sel),
        .stall     (stall),
        .in_grant  (grant_e),
        .outp      (outp_e),
        .out_valid (out_valid_e)
    );

    mux_to_demux_n_pipe #(.ID(2), .N(4), .WIDTH(16), .PIPE(2), .RR(1)) dut_r (
        .clock     (clock),
        .reset     (reset),
        .inp       (inp),
        .in_valid  (in_valid),
        .sel       (sel),
        .stall     (stall),
        .in_grant  (grant_r),
        .outp      (outp_r),
        .out_valid (out_valid_r)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        stall    = 1'b0;
        in_valid = 4'b1111;
        sel      = 2'd1;
        inp      = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        #1;
        total++;
        if (grant_e !== 4'b0000) begin bad++; $display("FAIL reset_grant_e got=%b want=0000", grant_e); end
        total++;
        if (grant_r !== 4'b0000) begin bad++; $display("FAIL reset_grant_r got=%b want=0000", grant_r); end
        tick();
        tick();
        total++;
        if (out_valid_e !== 4'b0000) begin bad++; $display("FAIL reset_out_valid_e got=%b want=0000", out_valid_e); end
        total++;
        if (outp_e !== 64'h0) begin bad++; $display("FAIL reset_outp_e got=%h want=0", outp_e); end
        total++;
        if (out_valid_r !== 4'b0000 || outp_r !== 64'h0) begin
            bad++; $display("FAIL reset_outputs_r got=%b/%h want=0000/0", out_valid_r, outp_r);
        end
        reset    = 1'b0;
        in_valid = 4'b0000;
    endtask

    task automatic test_explicit();
        inp[2]   = 16'hBEEF;
        sel      = 2'd2;
        in_valid = 4'b0100;
        #1;
        total++;
        if (grant_e !== 4'b0100) begin bad++; $display("FAIL explicit_grant got=%b want=0100", grant_e); end
        tick();
        in_valid = 4'b0000;
        tick();
        total++;
        if (out_valid_e !== 4'b0000) begin bad++; $display("FAIL explicit_early got=%b want=0000", out_valid_e); end
        tick();
        total++;
        if (out_valid_e !== 4'b0100) begin bad++; $display("FAIL explicit_valid got=%b want=0100", out_valid_e); end
        total++;
        if (outp_e !== {16'h0, 16'hBEEF, 16'h0, 16'h0}) begin
            bad++; $display("FAIL explicit_outp got=%h want=0000beef00000000", outp_e);
        end
        tick();
        total++;
        if (out_valid_e !== 4'b0000 || outp_e[2] !== 16'hBEEF) begin
            bad++; $display("FAIL explicit_after got=%b/%h want=0000/beef", out_valid_e, outp_e[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_data [4];
        logic [3:0]  exp_g;
        exp_data[0] = 16'h1111;
        exp_data[1] = 16'h2222;
        exp_data[2] = 16'h3333;
        exp_data[3] = 16'h4444;
        inp = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                sel      = 2'(i);
                in_valid = 4'b1111;
                exp_g    = 4'(1 << i);
            end else if (i == 4) begin
                sel      = 2'd3;
                in_valid = 4'b0111;
                exp_g    = 4'b0000;
            end else begin
                in_valid = 4'b0000;
                exp_g    = 4'b0000;
            end
            #1;
            total++;
            if (grant_e !== exp_g) begin bad++; $display("FAIL b2b_grant[%0d] got=%b want=%b", i, grant_e, exp_g); end
            tick();
            if (i >= 2 && i < 6) begin
                total++;
                if (out_valid_e !== 4'(1 << (i - 2)) || outp_e[i-2] !== exp_data[i-2]) begin
                    bad++;
                    $display("FAIL b2b_out[%0d] got=%b/%h want=%b/%h", i, out_valid_e, outp_e[i-2],
                             4'(1 << (i - 2)), exp_data[i-2]);
                end
            end else begin
                total++;
                if (out_valid_e !== 4'b0000) begin bad++; $display("FAIL b2b_idle[%0d] got=%b want=0000", i, out_valid_e); end
            end
        end
    endtask

    task automatic test_stall();
        inp[1]   = 16'h5151;
        sel      = 2'd1;
        in_valid = 4'b0010;
        tick();
        inp[0]   = 16'h5050;
        sel      = 2'd0;
        in_valid = 4'b0001;
        tick();
        stall = 1'b1;
        #1;
        total++;
        if (grant_e !== 4'b0000 || grant_r !== 4'b0000) begin
            bad++; $display("FAIL stall_grant got=%b/%b want=0000/0000", grant_e, grant_r);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid_e !== 4'b0000 || outp_e[1] !== 16'h2222 || outp_e[0] !== 16'h1111) begin
                bad++;
                $display("FAIL stall_frozen[%0d] got=%b/%h/%h want=0000/2222/1111", i, out_valid_e, outp_e[1], outp_e[0]);
            end
        end
        stall    = 1'b0;
        in_valid = 4'b0000;
        tick();
        total++;
        if (out_valid_e !== 4'b0010 || outp_e[1] !== 16'h5151) begin
            bad++; $display("FAIL stall_first got=%b/%h want=0010/5151", out_valid_e, outp_e[1]);
        end
        tick();
        total++;
        if (out_valid_e !== 4'b0001 || outp_e[0] !== 16'h5050) begin
            bad++; $display("FAIL stall_second got=%b/%h want=0001/5050", out_valid_e, outp_e[0]);
        end
        tick();
        total++;
        if (out_valid_e !== 4'b0000) begin bad++; $display("FAIL stall_drained got=%b want=0000", out_valid_e); end
    endtask

    task automatic test_reset_mid();
        inp[2]   = 16'h7777;
        sel      = 2'd2;
        in_valid = 4'b0100;
        tick();
        inp[3]   = 16'h8888;
        sel      = 2'd3;
        in_valid = 4'b1000;
        tick();
        reset    = 1'b1;
        in_valid = 4'b0000;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid_e !== 4'b0000) begin bad++; $display("FAIL midreset_pulse[%0d] got=%b want=0000", i, out_valid_e); end
        end
        total++;
        if (outp_e !== 64'h0) begin bad++; $display("FAIL midreset_outp got=%h want=0", outp_e); end
        in_valid = 4'b1111;
        #1;
        total++;
        if (grant_r !== 4'b0001) begin bad++; $display("FAIL midreset_rr_restart got=%b want=0001", grant_r); end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_rr();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b0010;
        exp_seq[1] = 4'b1000;
        exp_seq[2] = 4'b0010;
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            total++;
            if (grant_r !== 4'(1 << (i % 4))) begin
                bad++; $display("FAIL rr_full[%0d] got=%b want=%b", i, grant_r, 4'(1 << (i % 4)));
            end
            tick();
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (grant_r !== exp_seq[i]) begin bad++; $display("FAIL rr_sparse[%0d] got=%b want=%b", i, grant_r, exp_seq[i]); end
            tick();
        end
        in_valid = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        stall    = 1'b0;
        in_valid = 4'b0000;
        sel      = 2'd0;
        inp      = '0;
        test_reset();
        test_explicit();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_rr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
